// File: rtl/cacheline_adapter_pkg.sv
// Shared types and sizing for the cacheline <-> bmem burst adapter.
package cacheline_adapter_pkg;

    localparam int BEAT_W    = 64;
    localparam int BURST_LEN = 4;
    localparam int LINE_W    = BEAT_W * BURST_LEN;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR,
        RESP
    } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Converts one cacheline read/write from the arbiter into a BURST_LEN-beat
// burst on the bmem bus and returns a single-cycle dfp_resp. One transaction
// is in flight at a time; requests are only sampled in IDLE.
module cacheline_adapter #(
    parameter int BEAT_W    = cacheline_adapter_pkg::BEAT_W,
    parameter int BURST_LEN = cacheline_adapter_pkg::BURST_LEN
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   dfp_addr,
    input  logic                          dfp_read,
    input  logic                          dfp_write,
    input  logic [BEAT_W*BURST_LEN-1:0]   dfp_wdata,
    output logic [BEAT_W*BURST_LEN-1:0]   dfp_rdata,
    output logic                          dfp_resp,
    output logic [31:0]                   bmem_addr,
    output logic                          bmem_read,
    output logic                          bmem_write,
    output logic [BEAT_W-1:0]             bmem_wdata,
    input  logic                          bmem_ready,
    input  logic [31:0]                   bmem_raddr,
    input  logic [BEAT_W-1:0]             bmem_rdata,
    input  logic                          bmem_rvalid
);

    import cacheline_adapter_pkg::*;

    localparam int               LINE_W    = BEAT_W * BURST_LEN;
    localparam int               CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int               OFFSET_W  = $clog2(LINE_W / 8);
    localparam logic [31:0]      LINE_MASK = 32'((1 << OFFSET_W) - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    adapter_state_t    r_state;
    adapter_state_t    w_state_next;
    logic [CNT_W-1:0]  r_count;
    logic [31:0]       r_addr;
    // Holds the write line during WR and accumulates read beats during RD_DATA.
    logic [LINE_W-1:0] r_line;
    // Separate output copy so dfp_rdata stays stable while the next read fills r_line.
    logic [LINE_W-1:0] r_rdata;
    logic [LINE_W-1:0] w_line_cap;
    logic [BEAT_W-1:0] w_wbeat [BURST_LEN];
    logic              w_beat_hit;
    logic              w_last_beat;

    // Beat views of the line buffer: write-beat selection and read-beat insertion.
    generate
        for (genvar gi = 0; gi < BURST_LEN; gi++) begin : g_beat
            assign w_wbeat[gi] = r_line[gi*BEAT_W +: BEAT_W];
            assign w_line_cap[gi*BEAT_W +: BEAT_W] =
                (r_count == CNT_W'(gi)) ? bmem_rdata : r_line[gi*BEAT_W +: BEAT_W];
        end
    endgenerate

    // Only beats tagged with our latched line address count toward the burst.
    assign w_beat_hit  = bmem_rvalid && (bmem_raddr == r_addr);
    assign w_last_beat = (r_count == LAST_BEAT);
    assign dfp_rdata   = r_rdata;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and bus outputs decoded from the current state.
    always_comb begin
        w_state_next = r_state;
        bmem_read    = 1'b0;
        bmem_write   = 1'b0;
        bmem_addr    = '0;
        bmem_wdata   = '0;
        dfp_resp     = 1'b0;
        case (r_state)
            IDLE: begin
                // Write has priority when both requests are raised together.
                if (dfp_write) begin
                    w_state_next = WR;
                end else if (dfp_read) begin
                    w_state_next = RD_REQ;
                end
            end
            RD_REQ: begin
                bmem_read = 1'b1;
                bmem_addr = r_addr;
                if (bmem_ready) begin
                    w_state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                if (w_beat_hit && w_last_beat) begin
                    w_state_next = RESP;
                end
            end
            WR: begin
                bmem_write = 1'b1;
                bmem_addr  = r_addr;
                bmem_wdata = w_wbeat[r_count];
                if (bmem_ready && w_last_beat) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                // The arbiter drops its grant here, so any request still high is ignored.
                dfp_resp     = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath: address/line latching, beat counter and read-line assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_addr  <= '0;
            r_line  <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (dfp_write || dfp_read) begin
                        r_addr  <= dfp_addr & ~LINE_MASK;
                        r_count <= '0;
                    end
                    if (dfp_write) begin
                        r_line <= dfp_wdata;
                    end
                end
                RD_REQ: begin
                    if (bmem_ready) begin
                        r_count <= '0;
                    end
                end
                RD_DATA: begin
                    if (w_beat_hit) begin
                        r_line  <= w_line_cap;
                        r_count <= r_count + 1'b1;
                        if (w_last_beat) begin
                            r_rdata <= w_line_cap;
                        end
                    end
                end
                WR: begin
                    // A ready stall leaves the counter, and so the presented beat, unchanged.
                    if (bmem_ready) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: reads, writes, ready stalls,
// foreign read beats, request priority and mid-burst reset.
module tb_cacheline_adapter;

    logic         clk;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int n_checks = 0;
    int n_pass   = 0;
    logic [255:0] exp_rdata;

    cacheline_adapter dut (
        .clk         (clk),
        .rst         (rst),
        .dfp_addr    (dfp_addr),
        .dfp_read    (dfp_read),
        .dfp_write   (dfp_write),
        .dfp_wdata   (dfp_wdata),
        .dfp_rdata   (dfp_rdata),
        .dfp_resp    (dfp_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_resp"},   256'(dfp_resp),   256'(0));
        chk({tag, "_rd"},     256'(bmem_read),  256'(0));
        chk({tag, "_wr"},     256'(bmem_write), 256'(0));
        chk({tag, "_addr"},   256'(bmem_addr),  256'(0));
        chk({tag, "_wdata"},  256'(bmem_wdata), 256'(0));
    endtask

    // Drive one write request, act as bmem, and check every presented beat.
    task automatic do_write(input string tag, input logic [31:0] addr, input logic [255:0] data,
                            input bit also_read, input int stall_beat, input int stall_len,
                            input int exp_resp_cyc);
        int cyc, nacc, stalled, resp_cyc, nrd, nextra;
        logic [63:0] beat;
        cyc = 1; nacc = 0; stalled = 0; resp_cyc = 0; nrd = 0; nextra = 0;
        dfp_addr = addr; dfp_wdata = data; dfp_write = 1'b1; dfp_read = also_read;
        bmem_ready = 1'b1;
        while (cyc < 40 && resp_cyc == 0) begin
            if (bmem_read) nrd++;
            if (bmem_write) begin
                if (nacc < 4) begin
                    beat = data[nacc*64 +: 64];
                    chk({tag, "_addr"},  256'(bmem_addr),  256'({addr[31:5], 5'b0}));
                    chk({tag, "_wbeat"}, 256'(bmem_wdata), 256'(beat));
                end else begin
                    nextra++;
                end
                if (nacc == stall_beat && stalled < stall_len) begin
                    bmem_ready = 1'b0;
                    stalled++;
                end else begin
                    bmem_ready = 1'b1;
                    nacc++;
                end
            end
            if (dfp_resp) begin
                resp_cyc = cyc;
                dfp_write = 1'b0;
                dfp_read = 1'b0;
            end
            tick();
            cyc++;
        end
        bmem_ready = 1'b1;
        chk({tag, "_resp_cycle"},  256'(resp_cyc), 256'(exp_resp_cyc));
        chk({tag, "_beats"},       256'(nacc),     256'(4));
        chk({tag, "_extra_beats"}, 256'(nextra),   256'(0));
        chk({tag, "_rd_cycles"},   256'(nrd),      256'(0));
        chk({tag, "_resp_single"}, 256'(dfp_resp), 256'(0));
        chk({tag, "_rdata_hold"},  dfp_rdata,      exp_rdata);
        $display("write %s addr=%h resp_cycle=%0d beats=%0d", tag, addr, resp_cyc, nacc);
    endtask

    // Drive one read request and return beats; foreign_at >= 0 slips a beat
    // tagged 0x3000 in before that beat index.
    task automatic do_read(input string tag, input logic [31:0] addr, input logic [255:0] line,
                           input int foreign_at, input int exp_resp_cyc);
        int cyc, fed, resp_cyc, last_cyc, nwr;
        bit granted, fdone;
        cyc = 1; fed = 0; resp_cyc = 0; last_cyc = 0; nwr = 0; granted = 0; fdone = 0;
        dfp_addr = addr; dfp_read = 1'b1; dfp_write = 1'b0; bmem_ready = 1'b1;
        while (cyc < 40 && resp_cyc == 0) begin
            bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
            if (bmem_write) nwr++;
            if (dfp_resp) begin
                resp_cyc = cyc;
                dfp_read = 1'b0;
                chk({tag, "_rdata"}, dfp_rdata, line);
            end else begin
                chk({tag, "_rdata_prev"}, dfp_rdata, exp_rdata);
                if (granted) begin
                    if (!fdone && fed == foreign_at) begin
                        bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_3000;
                        bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF; fdone = 1;
                    end else if (fed < 4) begin
                        bmem_rvalid = 1'b1; bmem_raddr = {addr[31:5], 5'b0};
                        bmem_rdata = line[fed*64 +: 64]; fed++;
                        if (fed == 4) last_cyc = cyc;
                    end
                end
                if (bmem_read) begin
                    chk({tag, "_raddr_cmd"}, 256'(bmem_addr), 256'({addr[31:5], 5'b0}));
                    granted = 1;
                end
            end
            tick();
            cyc++;
        end
        bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
        exp_rdata = line;
        chk({tag, "_resp_cycle"},  256'(resp_cyc), 256'(exp_resp_cyc));
        chk({tag, "_resp_lat"},    256'(resp_cyc), 256'(last_cyc + 1));
        chk({tag, "_wr_cycles"},   256'(nwr),      256'(0));
        chk({tag, "_resp_single"}, 256'(dfp_resp), 256'(0));
        chk({tag, "_rdata_after"}, dfp_rdata,      line);
        $display("read %s addr=%h resp_cycle=%0d", tag, addr, resp_cyc);
    endtask

    localparam logic [255:0] LINE1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] WLINE = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                      64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    localparam logic [255:0] WLINE2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                       64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0};
    localparam logic [255:0] LINE4 = {64'h8888_0000_8888_0004, 64'h7777_0000_7777_0003,
                                      64'h6666_0000_6666_0002, 64'h5555_0000_5555_0001};
    localparam logic [255:0] LINE6 = {64'hC0DE_0000_0000_0004, 64'hC0DE_0000_0000_0003,
                                      64'hC0DE_0000_0000_0002, 64'hC0DE_0000_0000_0001};

    initial begin
        rst = 1'b1;
        dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
        bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        exp_rdata = '0;
        tick();
        tick();
        chk_idle_outputs("reset");
        chk("reset_rdata", dfp_rdata, 256'(0));
        rst = 1'b0;
        tick();
        chk_idle_outputs("idle");
        $display("reset outputs checked");

        // 1: plain read, back-to-back beats
        do_read("t1_read", 32'h0000_1000, LINE1, -1, 7);

        // 2: write from an unaligned address, best-case timing
        do_write("t2_write", 32'h0000_2004, WLINE, 1'b0, -1, 0, 6);

        // 3: ready held low for three cycles on beat index 2
        do_write("t3_stall", 32'h0000_2040, WLINE2, 1'b0, 2, 3, 9);

        // 4: a foreign-tagged beat interleaved mid-burst
        do_read("t4_foreign", 32'h0000_1000, LINE4, 2, 8);

        // 5: read and write raised together -> write only
        do_write("t5_both", 32'h0000_4010, WLINE, 1'b1, -1, 0, 6);

        // 6: reset after two beats of a read, trailing beats in IDLE
        dfp_addr = 32'h0000_1000; dfp_read = 1'b1; bmem_ready = 1'b1;
        tick();
        chk("t6_rd_cmd", 256'(bmem_read), 256'(1));
        tick();
        bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_1000; bmem_rdata = LINE6[63:0];
        tick();
        bmem_rdata = LINE6[127:64];
        tick();
        bmem_rdata = LINE6[191:128];
        rst = 1'b1; dfp_read = 1'b0;
        tick();
        chk_idle_outputs("t6_rst");
        chk("t6_rst_rdata", dfp_rdata, 256'(0));
        exp_rdata = '0;
        rst = 1'b0;
        tick();
        chk("t6_stale_resp", 256'(dfp_resp), 256'(0));
        chk("t6_stale_rd",   256'(bmem_read), 256'(0));
        bmem_rdata = LINE6[255:192];
        tick();
        bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
        tick();
        chk("t6_stale_resp2", 256'(dfp_resp), 256'(0));
        chk("t6_stale_rdata", dfp_rdata, 256'(0));
        $display("reset mid-burst checked");
        do_read("t6_reread", 32'h0000_1000, LINE6, -1, 7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
